// File: rtl/con_resp_arbiter.sv
// con_resp_arbiter
// Merges the byte frames of four responder blocks onto the single control
// response stream. Each channel buffers whole frames in its own FIFO. Complete
// frames are then replayed one at a time: contiguously, round robin, and with
// an idle gap between frames.
// Optional feature macro: CON_ARB_PRIORITY_EN gives channel 0 fixed top
// priority whenever the arbiter picks a new frame.
module con_resp_arbiter #(
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_FRAME  = 16,
  parameter int MIN_GAP    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_din,
  input  logic [3:0]  req_din_en,
  output logic [7:0]  con_dout,
  output logic        con_dout_en,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [3:0]  ovf_flag
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int LW       = $clog2(MAX_FRAME + 1);
  localparam int GW       = (MIN_GAP > 2) ? $clog2(MIN_GAP - 1) : 1;
  localparam int GAP_LAST = (MIN_GAP > 1) ? MIN_GAP - 2 : 0;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t state, state_nxt;

  // FIFO storage: bit 8 marks the last byte of a frame
  logic [8:0]    mem [4][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [4];
  logic [AW-1:0] rd_ptr [4];
  logic [CW-1:0] occ [4];
  logic [CW-1:0] free_cnt [4];
  logic [CW-1:0] frame_cnt [4];

  // Write-side staging and run tracking
  logic [7:0]    stg_data [4];
  logic [3:0]    stg_valid;
  logic [3:0]    run_active;
  logic [3:0]    run_drop;
  logic [LW-1:0] run_len [4];

  logic [3:0]    first_byte;
  logic [3:0]    admit;
  logic [3:0]    accept;
  logic [3:0]    wr_en;
  logic [3:0]    pop;

  // Read side
  logic [8:0]    head;
  logic [3:0]    has_frame;
  logic [1:0]    rr_base;
  logic [1:0]    cand;
  logic [1:0]    sel;
  logic          found;
  logic          granted_once;
  logic          send_pop;
  logic          load_grant;
  logic [GW-1:0] gap_cnt;

  // Per-channel admission, truncation and FIFO write/pop decisions
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      free_cnt[i]   = CW'(FIFO_DEPTH) - occ[i];
      first_byte[i] = req_din_en[i] & ~run_active[i];
      admit[i]      = first_byte[i] & (free_cnt[i] >= CW'(MAX_FRAME));
      if (first_byte[i]) begin
        accept[i] = admit[i];
      end else begin
        accept[i] = req_din_en[i] & ~run_drop[i] & (run_len[i] < LW'(MAX_FRAME));
      end
      wr_en[i] = stg_valid[i] & (accept[i] | ~req_din_en[i]);
      pop[i]   = send_pop & (grant == 2'(i));
    end
  end

  // Staging registers, run state, sticky overflow flags and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid  <= '0;
      run_active <= '0;
      run_drop   <= '0;
      ovf_flag   <= '0;
      for (int i = 0; i < 4; i++) begin
        stg_data[i]  <= '0;
        run_len[i]   <= '0;
        wr_ptr[i]    <= '0;
        rd_ptr[i]    <= '0;
        occ[i]       <= '0;
        frame_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        run_active[i] <= req_din_en[i];
        if (first_byte[i]) begin
          run_drop[i] <= ~admit[i];
          if (!admit[i]) begin
            ovf_flag[i] <= 1'b1;
          end
        end
        if (accept[i]) begin
          stg_data[i]  <= req_din[8*i +: 8];
          stg_valid[i] <= 1'b1;
          run_len[i]   <= first_byte[i] ? LW'(1) : run_len[i] + LW'(1);
        end else if (!req_din_en[i]) begin
          stg_valid[i] <= 1'b0;
        end
        if (wr_en[i]) begin
          wr_ptr[i] <= wr_ptr[i] + AW'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + AW'(1);
        end
        occ[i]       <= occ[i] + CW'(wr_en[i]) - CW'(pop[i]);
        frame_cnt[i] <= frame_cnt[i] + CW'(wr_en[i] & ~req_din_en[i])
                        - CW'(pop[i] & head[8]);
      end
    end
  end

  // FIFO array write; the byte is marked last when its run has just ended
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) begin
        mem[i][wr_ptr[i]] <= {~req_din_en[i], stg_data[i]};
      end
    end
  end

  // Head entry of the granted channel and per-channel frame availability
  always_comb begin
    head = mem[grant][rd_ptr[grant]];
    for (int i = 0; i < 4; i++) begin
      has_frame[i] = (frame_cnt[i] != '0);
    end
  end

  // Round-robin pick starting after the last grant (channel 0 after reset)
  always_comb begin
    rr_base = granted_once ? grant + 2'd1 : 2'd0;
    sel     = rr_base;
    cand    = rr_base;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_base + 2'(k);
      if (!found && has_frame[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
`ifdef CON_ARB_PRIORITY_EN
    if (has_frame[0]) begin
      sel = 2'd0;
    end
`else
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; the output register adds one idle cycle, so GAP itself
  // lasts MIN_GAP-1 cycles to give exactly MIN_GAP idle output cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|has_frame) state_nxt = SEND;
      SEND: if (head[8]) state_nxt = (MIN_GAP > 1) ? GAP : IDLE;
      GAP:  if (gap_cnt == GW'(GAP_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state != IDLE);
    send_pop   = (state == SEND);
    load_grant = (state == IDLE) && (|has_frame);
  end

  // Grant register, output byte register and gap timer
  always_ff @(posedge clk) begin
    if (rst) begin
      grant        <= 2'd0;
      granted_once <= 1'b0;
      con_dout     <= 8'd0;
      con_dout_en  <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      if (load_grant) begin
        grant        <= sel;
        granted_once <= 1'b1;
      end
      if (send_pop) begin
        con_dout    <= head[7:0];
        con_dout_en <= 1'b1;
      end else begin
        con_dout    <= 8'd0;
        con_dout_en <= 1'b0;
      end
      if (state == GAP) begin
        gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_con_resp_arbiter.sv
// tb_con_resp_arbiter
// Directed bench for con_resp_arbiter (default parameters, priority macro off).
// Input frames are described as {channel, start cycle, length, first byte};
// expected output frames as {channel, first output cycle, length, first byte}.
module tb_con_resp_arbiter;

  localparam int NREC = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_din;
  logic [3:0]  req_din_en;
  logic [7:0]  con_dout;
  logic        con_dout_en;
  logic [1:0]  grant;
  logic        busy;
  logic [3:0]  ovf_flag;

  con_resp_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_din    (req_din),
    .req_din_en (req_din_en),
    .con_dout   (con_dout),
    .con_dout_en(con_dout_en),
    .grant      (grant),
    .busy       (busy),
    .ovf_flag   (ovf_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    int         start;
    int         len;
    logic [7:0] base;
  } in_frame_t;

  typedef struct {
    int         ch;
    int         first;
    int         len;
    logic [7:0] base;
  } out_frame_t;

  typedef struct {
    int         ch;
    int         len;
    logic [7:0] base;
    int         exp_len;
    int         exp_first;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int run_cycles = 0;
  int mon_rel;
  bit rec_on = 1'b0;

  in_frame_t  in_plan[$];
  out_frame_t exp_plan[$];

  logic       mon_en    [NREC];
  logic [7:0] mon_data  [NREC];
  logic [1:0] mon_grant [NREC];
  logic       mon_busy  [NREC];
  logic [3:0] mon_ovf   [NREC];
  int         mon_fc0   [NREC];

  // Free-running cycle counter used to timestamp outputs
  always @(posedge clk) cyc <= cyc + 1;

  // Record DUT outputs mid-cycle, indexed by cycle relative to run start
  always @(negedge clk) begin
    if (rec_on) begin
      mon_rel = cyc - t0;
      if (mon_rel >= 0 && mon_rel < NREC) begin
        mon_en[mon_rel]    = con_dout_en;
        mon_data[mon_rel]  = con_dout;
        mon_grant[mon_rel] = grant;
        mon_busy[mon_rel]  = busy;
        mon_ovf[mon_rel]   = ovf_flag;
        mon_fc0[mon_rel]   = int'(dut.frame_cnt[0]);
      end
    end
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_din_en = '0;
    req_din = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive the frames in in_plan for ncycles cycles; rst pulses at rst_at
  task automatic applyStimulus(input int ncycles, input int rst_at);
    run_cycles = ncycles;
    @(posedge clk); #1;
    t0 = cyc;
    rec_on = 1'b1;
    for (int t = 0; t < ncycles; t++) begin
      logic [3:0]  en_v;
      logic [31:0] din_v;
      en_v  = '0;
      din_v = '0;
      foreach (in_plan[f]) begin
        if (t >= in_plan[f].start && t < in_plan[f].start + in_plan[f].len) begin
          en_v[in_plan[f].ch] = 1'b1;
          din_v[8*in_plan[f].ch +: 8] = in_plan[f].base + 8'(t - in_plan[f].start);
        end
      end
      req_din_en = en_v;
      req_din    = din_v;
      rst        = (t == rst_at);
      @(posedge clk); #1;
    end
    rec_on     = 1'b0;
    req_din_en = '0;
    req_din    = '0;
    rst        = 1'b0;
  endtask

  // Compare recorded output against exp_plan, byte count, zeroing, flags
  task automatic checkOutput(input string name, input logic [3:0] exp_ovf);
    int exp_total;
    int act_total;
    int bad_zero;
    exp_total = 0;
    act_total = 0;
    bad_zero  = 0;
    foreach (exp_plan[k]) begin
      int         bad_at;
      int         c;
      logic [7:0] want;
      logic       got_en;
      logic [7:0] got_d;
      logic [1:0] got_g;
      logic [7:0] want_d;
      bad_at = -1;
      got_en = 1'b0;
      got_d  = '0;
      got_g  = '0;
      want_d = '0;
      for (int j = 0; j < exp_plan[k].len; j++) begin
        c    = exp_plan[k].first + j;
        want = exp_plan[k].base + 8'(j);
        if (c >= run_cycles) begin
          bad_at = j;
          want_d = want;
          break;
        end
        if (!mon_en[c] || mon_data[c] != want || mon_grant[c] != 2'(exp_plan[k].ch)) begin
          bad_at = j;
          got_en = mon_en[c];
          got_d  = mon_data[c];
          got_g  = mon_grant[c];
          want_d = want;
          break;
        end
      end
      exp_total += exp_plan[k].len;
      checks++;
      if (bad_at >= 0) begin
        errors++;
        $display("[TB] FAIL %s frame%0d byte%0d: got en=%0b data=%02h grant=%0d, want en=1 data=%02h grant=%0d",
                 name, k, bad_at, got_en, got_d, got_g, want_d, exp_plan[k].ch);
      end
    end
    for (int c = 0; c < run_cycles; c++) begin
      if (mon_en[c]) act_total++;
      else if (mon_data[c] != 8'd0) bad_zero++;
    end
    checks++;
    if (act_total != exp_total) begin
      errors++;
      $display("[TB] FAIL %s byte_count: got %0d, want %0d", name, act_total, exp_total);
    end
    checks++;
    if (bad_zero != 0) begin
      errors++;
      $display("[TB] FAIL %s dout_idle_zero: got %0d nonzero idle cycles, want 0", name, bad_zero);
    end
    checks++;
    if (mon_ovf[run_cycles-1] != exp_ovf) begin
      errors++;
      $display("[TB] FAIL %s ovf_flag: got %04b, want %04b", name, mon_ovf[run_cycles-1], exp_ovf);
    end
    checks++;
    if (mon_busy[run_cycles-1] != 1'b0) begin
      errors++;
      $display("[TB] FAIL %s busy_end: got %0b, want 0", name, mon_busy[run_cycles-1]);
    end
  endtask

  task automatic check_at(input string name, input int c, input logic en_exp,
                          input logic busy_exp, input logic [3:0] ovf_exp);
    checks++;
    if (mon_en[c] != en_exp || mon_busy[c] != busy_exp || mon_ovf[c] != ovf_exp) begin
      errors++;
      $display("[TB] FAIL %s cycle%0d: got en=%0b busy=%0b ovf=%04b, want en=%0b busy=%0b ovf=%04b",
               name, c, mon_en[c], mon_busy[c], mon_ovf[c], en_exp, busy_exp, ovf_exp);
    end
  endtask

  vec_t vecs[5];

  initial begin
    // Single-channel vectors: latency is commit cycle (start+len) plus 3
    vecs[0] = '{ch: 2, len: 15, base: 8'h01, exp_len: 15, exp_first: 19};
    vecs[1] = '{ch: 3, len: 20, base: 8'h40, exp_len: 16, exp_first: 24};
    vecs[2] = '{ch: 0, len: 1,  base: 8'hA5, exp_len: 1,  exp_first: 5};
    vecs[3] = '{ch: 1, len: 16, base: 8'hF8, exp_len: 16, exp_first: 20};
    vecs[4] = '{ch: 3, len: 17, base: 8'h33, exp_len: 16, exp_first: 21};

    rst        = 1'b1;
    req_din    = '0;
    req_din_en = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (con_dout !== 8'd0 || con_dout_en !== 1'b0 || grant !== 2'd0 ||
        busy !== 1'b0 || ovf_flag !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got dout=%02h en=%0b grant=%0d busy=%0b ovf=%04b, want all 0",
               con_dout, con_dout_en, grant, busy, ovf_flag);
    end
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_reset();
      in_plan.delete();
      exp_plan.delete();
      in_plan.push_back('{ch: vecs[i].ch, start: 1, len: vecs[i].len, base: vecs[i].base});
      exp_plan.push_back('{ch: vecs[i].ch, first: vecs[i].exp_first, len: vecs[i].exp_len,
                           base: vecs[i].base});
      applyStimulus(vecs[i].exp_first + vecs[i].exp_len + 6, -1);
      checkOutput($sformatf("vec%0d", i), 4'b0000);
    end

    // Contention: four frames commit together; order 0,1,2,3 with 2 idle cycles
    do_reset();
    in_plan.delete();
    exp_plan.delete();
    for (int k = 0; k < 4; k++) begin
      in_plan.push_back('{ch: k, start: 1, len: 4, base: 8'(16 * (k + 1))});
      exp_plan.push_back('{ch: k, first: 8 + 6 * k, len: 4, base: 8'(16 * (k + 1))});
    end
    applyStimulus(36, -1);
    checkOutput("contention", 4'b0000);

    // Round robin resumes after the last grant: ch1, then ch2 before ch0
    do_reset();
    in_plan.delete();
    exp_plan.delete();
    in_plan.push_back('{ch: 1, start: 1, len: 4, base: 8'h50});
    in_plan.push_back('{ch: 0, start: 2, len: 4, base: 8'h00});
    in_plan.push_back('{ch: 2, start: 2, len: 4, base: 8'h20});
    exp_plan.push_back('{ch: 1, first: 8,  len: 4, base: 8'h50});
    exp_plan.push_back('{ch: 2, first: 14, len: 4, base: 8'h20});
    exp_plan.push_back('{ch: 0, first: 20, len: 4, base: 8'h00});
    applyStimulus(30, -1);
    checkOutput("round_robin", 4'b0000);

    // Commit of frame B coincides with the pop of frame A's last byte
    do_reset();
    in_plan.delete();
    exp_plan.delete();
    in_plan.push_back('{ch: 0, start: 1, len: 4, base: 8'h70});
    in_plan.push_back('{ch: 0, start: 6, len: 4, base: 8'h90});
    exp_plan.push_back('{ch: 0, first: 8,  len: 4, base: 8'h70});
    exp_plan.push_back('{ch: 0, first: 14, len: 4, base: 8'h90});
    applyStimulus(24, -1);
    checkOutput("same_cycle_wr_rd", 4'b0000);
    checks++;
    if (mon_fc0[11] != 1) begin
      errors++;
      $display("[TB] FAIL frame_cnt0_after_overlap: got %0d, want 1", mon_fc0[11]);
    end

    // Overflow: ch0 holds the output while ch1 fills its FIFO; third frame dropped
    do_reset();
    in_plan.delete();
    exp_plan.delete();
    in_plan.push_back('{ch: 0, start: 1,  len: 16, base: 8'hA0});
    in_plan.push_back('{ch: 1, start: 2,  len: 16, base: 8'h10});
    in_plan.push_back('{ch: 1, start: 19, len: 16, base: 8'h30});
    in_plan.push_back('{ch: 1, start: 36, len: 16, base: 8'h50});
    exp_plan.push_back('{ch: 0, first: 20, len: 16, base: 8'hA0});
    exp_plan.push_back('{ch: 1, first: 38, len: 16, base: 8'h10});
    exp_plan.push_back('{ch: 1, first: 56, len: 16, base: 8'h30});
    applyStimulus(80, -1);
    checkOutput("overflow", 4'b0010);

    // Reset during output byte 5 (no reset beforehand, so ovf_flag is still set)
    in_plan.delete();
    exp_plan.delete();
    in_plan.push_back('{ch: 1, start: 1, len: 10, base: 8'h60});
    exp_plan.push_back('{ch: 1, first: 14, len: 5, base: 8'h60});
    applyStimulus(40, 18);
    checkOutput("reset_mid_send", 4'b0000);
    check_at("reset_mid_send_before", 17, 1'b1, 1'b1, 4'b0010);
    check_at("reset_mid_send_after", 19, 1'b0, 1'b0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
